dp_psum_buf: RTL and testbench

//  Responder for the DP madd next-stage partial-sum port: stores psum words written by madd_top
//  (nxt_we/wraddr/dout) and returns psum words on nxt_rdaddr after a fixed delay.

---
 rtl/dp_psum_buf_pkg.sv | 40 ++++
 rtl/dp_psum_buf_if.sv | 42 ++++
 rtl/dp_psum_buf_ram.sv | 48 ++++
 rtl/dp_psum_buf.sv | 185 ++++++++++++++++++
 tb/tb_dp_psum_buf.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_psum_buf_pkg.sv
// ============================================================================
//  Module      : dp_psum_buf_pkg
//  Description : Shared configuration, derived widths and FSM encoding for
//                the DP partial-sum buffer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dp_psum_buf_pkg;

    localparam int COE_WIDTH         = 35;
    localparam int NUM_POLY          = 3;
    localparam int ADDR_WIDTH        = 9;
    localparam int LOG_NUM_BANK      = 3;
    localparam int COMMON_BRAM_DELAY = 1;

    localparam int W          = COE_WIDTH * NUM_POLY;
    localparam int AW         = ADDR_WIDTH + LOG_NUM_BANK;
    localparam int DEPTH      = 1 << AW;
    localparam int FIFO_DEPTH = COMMON_BRAM_DELAY + 1;

    typedef logic [AW-1:0] addr_t;
    typedef logic [W-1:0]  word_t;

    localparam addr_t ADDR_LAST = addr_t'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Saturating increment: address counters stop at the last word, never wrap.
    function automatic addr_t addr_inc(input addr_t a);
        return (a == ADDR_LAST) ? a : a + addr_t'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dp_psum_buf_if.sv
// ============================================================================
//  Module      : dp_psum_buf_if
//  Description : Next-stage psum port, clear/drain control and drain stream.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dp_psum_buf_if;
    import dp_psum_buf_pkg::*;

    logic  i_nxt_we;
    addr_t i_nxt_wraddr;
    word_t i_nxt_din;
    addr_t i_nxt_rdaddr;
    word_t o_nxt_psum;
    logic  i_clear_start;
    logic  i_drain_start;
    logic  o_drain_valid;
    logic  i_drain_ready;
    word_t o_drain_data;
    addr_t o_drain_addr;
    logic  o_drain_last;
    logic  o_busy;
    logic  o_done;

    modport slave (
        input  i_nxt_we, i_nxt_wraddr, i_nxt_din, i_nxt_rdaddr,
        input  i_clear_start, i_drain_start, i_drain_ready,
        output o_nxt_psum, o_drain_valid, o_drain_data, o_drain_addr,
        output o_drain_last, o_busy, o_done
    );

    modport master (
        output i_nxt_we, i_nxt_wraddr, i_nxt_din, i_nxt_rdaddr,
        output i_clear_start, i_drain_start, i_drain_ready,
        input  o_nxt_psum, o_drain_valid, o_drain_data, o_drain_addr,
        input  o_drain_last, o_busy, o_done
    );

endinterface

`default_nettype wire

// File: rtl/dp_psum_buf_ram.sv
// ============================================================================
//  Module      : dp_psum_buf_ram
//  Description : Simple dual-port read-first RAM, DEPTH x W, read latency
//                COMMON_BRAM_DELAY cycles. Array contents are not reset.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dp_psum_buf_ram
    import dp_psum_buf_pkg::*;
(
    input  wire          clk,
    input  wire          rst,
    input  wire          i_we,
    input  wire [AW-1:0] i_waddr,
    input  wire [W-1:0]  i_wdata,
    input  wire [AW-1:0] i_raddr,
    output word_t        o_rdata
);

    word_t r_mem  [DEPTH];
    word_t r_pipe [COMMON_BRAM_DELAY];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reading the array with a non-blocking write pending gives old data on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < COMMON_BRAM_DELAY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= r_mem[i_raddr];
            for (int i = 1; i < COMMON_BRAM_DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_rdata = r_pipe[COMMON_BRAM_DELAY-1];

endmodule

`default_nettype wire

// File: rtl/dp_psum_buf.sv
// ============================================================================
//  Module      : dp_psum_buf
//  Description : Partial-sum buffer with clear engine and credit-limited drain
//                streaming through a small skid FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dp_psum_buf
    import dp_psum_buf_pkg::*;
(
    input  wire          clk,
    input  wire          rst,
    dp_psum_buf_if.slave bus
);

    localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int IFW = $clog2(COMMON_BRAM_DELAY + 1);
    localparam logic [FPW-1:0] PTR_LAST = FPW'(FIFO_DEPTH - 1);

    state_e r_state, w_state_nxt;
    addr_t  r_clr_cnt;
    addr_t  r_rd_ptr;
    logic   r_rd_done;
    logic   r_done;

    logic [COMMON_BRAM_DELAY-1:0] r_vld;
    addr_t                        r_apipe [COMMON_BRAM_DELAY];

    word_t          r_fdata [FIFO_DEPTH];
    addr_t          r_faddr [FIFO_DEPTH];
    logic [FPW-1:0] r_wptr, r_rptr;
    logic [FCW-1:0] r_fcnt;

    logic           w_ram_we;
    addr_t          w_ram_waddr, w_ram_raddr;
    word_t          w_ram_wdata, w_ram_rdata;
    logic           w_issue, w_push, w_pop, w_head_last, w_credit_ok, w_done_nxt;
    logic [IFW-1:0] w_inflight;

    function automatic logic [FPW-1:0] ptr_inc(input logic [FPW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + FPW'(1);
    endfunction

    dp_psum_buf_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    assign w_push      = r_vld[COMMON_BRAM_DELAY-1];
    assign w_pop       = (r_fcnt != '0) && bus.i_drain_ready;
    assign w_head_last = (r_faddr[r_rptr] == ADDR_LAST);

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < COMMON_BRAM_DELAY; i++) begin
            w_inflight = w_inflight + IFW'(r_vld[i]);
        end
    end

    // The slot freed by this cycle's pop is usable, which sustains one word per cycle.
    assign w_credit_ok = (int'(r_fcnt) - int'(w_pop) + int'(w_inflight)) < FIFO_DEPTH;

    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_waddr = bus.i_nxt_wraddr;
        w_ram_wdata = bus.i_nxt_din;
        w_ram_raddr = bus.i_nxt_rdaddr;
        w_issue     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ram_we = bus.i_nxt_we;
                if (bus.i_clear_start) begin
                    w_state_nxt = ST_CLEAR;
                end else if (bus.i_drain_start) begin
                    // First read goes out with the start pulse to hit the first-valid latency.
                    w_state_nxt = ST_DRAIN;
                    w_issue     = 1'b1;
                    w_ram_raddr = r_rd_ptr;
                end
            end
            ST_CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_clr_cnt;
                w_ram_wdata = '0;
                if (r_clr_cnt == ADDR_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_ram_raddr = r_rd_ptr;
                w_issue     = !r_rd_done && w_credit_ok;
                if (w_pop && w_head_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_done    <= 1'b0;
            r_clr_cnt <= '0;
            r_rd_ptr  <= '0;
            r_rd_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_clr_cnt <= (r_state == ST_CLEAR) ? addr_inc(r_clr_cnt) : '0;
            if (w_issue) begin
                r_rd_ptr  <= addr_inc(r_rd_ptr);
                r_rd_done <= (r_rd_ptr == ADDR_LAST);
            end else if (r_state != ST_DRAIN) begin
                r_rd_ptr  <= '0;
                r_rd_done <= 1'b0;
            end
        end
    end

    // Read tags track the RAM latency so each returning word knows its address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < COMMON_BRAM_DELAY; i++) begin
                r_apipe[i] <= '0;
            end
        end else begin
            r_vld[0]   <= w_issue;
            r_apipe[0] <= r_rd_ptr;
            for (int i = 1; i < COMMON_BRAM_DELAY; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_apipe[i] <= r_apipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fdata[i] <= '0;
                r_faddr[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fdata[r_wptr] <= w_ram_rdata;
                r_faddr[r_wptr] <= r_apipe[COMMON_BRAM_DELAY-1];
                r_wptr          <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + FCW'(1);
                2'b01:   r_fcnt <= r_fcnt - FCW'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    assign bus.o_nxt_psum    = w_ram_rdata;
    assign bus.o_drain_valid = (r_fcnt != '0);
    assign bus.o_drain_data  = r_fdata[r_rptr];
    assign bus.o_drain_addr  = r_faddr[r_rptr];
    assign bus.o_drain_last  = (r_fcnt != '0) && w_head_last;
    assign bus.o_busy        = (r_state != ST_IDLE);
    assign bus.o_done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_dp_psum_buf.sv
// ============================================================================
//  Module      : tb_dp_psum_buf
//  Description : Directed/random bench for dp_psum_buf against an array model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dp_psum_buf;
    import dp_psum_buf_pkg::*;

    logic clk;
    logic rst;
    int   n_err;
    int   n_chk;

    word_t model [DEPTH];

    dp_psum_buf_if bus();

    dp_psum_buf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic word_t rnd_word();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic wr(input addr_t a, input word_t d);
        bus.i_nxt_we     = 1'b1;
        bus.i_nxt_wraddr = a;
        bus.i_nxt_din    = d;
        model[a]         = d;
        tick();
        bus.i_nxt_we     = 1'b0;
    endtask

    task automatic rd(input addr_t a, input string tag);
        bus.i_nxt_rdaddr = a;
        repeat (COMMON_BRAM_DELAY) tick();
        chk(tag, bus.o_nxt_psum, model[a]);
    endtask

    task automatic fill(input bit ramp);
        for (int a = 0; a < DEPTH; a++) begin
            bus.i_nxt_we     = 1'b1;
            bus.i_nxt_wraddr = addr_t'(a);
            bus.i_nxt_din    = ramp ? W'(a) : rnd_word();
            model[a]         = bus.i_nxt_din;
            tick();
        end
        bus.i_nxt_we = 1'b0;
    endtask

    // Clear, with nxt writes to 2047 held during busy; optionally collides/injects drain starts.
    task automatic clear_run(input bit both, input bit inject);
        int busy_n, done_n, valid_n, after_n;
        busy_n = 0; done_n = 0; valid_n = 0; after_n = 0;
        bus.i_clear_start = 1'b1;
        bus.i_drain_start = both;
        tick();
        bus.i_clear_start = 1'b0;
        bus.i_drain_start = 1'b0;
        for (int c = 1; c < DEPTH + 16; c++) begin
            if (bus.o_busy) busy_n++;
            if (bus.o_done) done_n++;
            if (bus.o_drain_valid) valid_n++;
            bus.i_nxt_we      = bus.o_busy;
            bus.i_nxt_wraddr  = addr_t'(2047);
            bus.i_nxt_din     = W'(32'hdead);
            bus.i_drain_start = inject && (c == 100);
            if (bus.o_done) break;
            tick();
        end
        bus.i_nxt_we = 1'b0;
        bus.i_drain_start = 1'b0;
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        repeat (COMMON_BRAM_DELAY + 3) begin
            tick();
            if (bus.o_busy || bus.o_done || bus.o_drain_valid) after_n++;
        end
        chk("clear_busy_cycles", W'(busy_n), W'(DEPTH));
        chk("clear_done_pulses", W'(done_n), W'(1));
        chk("clear_no_drain", W'(valid_n), W'(0));
        chk("clear_quiet_after", W'(after_n), W'(0));
    endtask

    task automatic drain_run(input int pct, input bit stall, input int abort_beat);
        int cyc, exp_idx, first_v, last_hs, done_n, max_occ, stall_err, quiet;
        bit prev_stall, aborted, hs;
        word_t prev_data;
        addr_t prev_addr;
        cyc = 0; exp_idx = 0; first_v = -1; last_hs = -1; done_n = 0;
        max_occ = 0; stall_err = 0; quiet = 0;
        prev_stall = 1'b0; aborted = 1'b0; prev_data = '0; prev_addr = '0;
        bus.i_drain_start = 1'b1;
        bus.i_drain_ready = 1'b0;
        tick();
        bus.i_drain_start = 1'b0;
        cyc = 1;
        while (cyc < 8 * DEPTH) begin
            if (bus.o_done) begin
                done_n++;
                chk("drain_done_cycle", W'(cyc), W'(last_hs + 1));
                break;
            end
            if (prev_stall && !(bus.o_drain_valid && bus.o_drain_data === prev_data
                                && bus.o_drain_addr === prev_addr)) stall_err++;
            if (int'(dut.r_fcnt) > max_occ) max_occ = int'(dut.r_fcnt);
            if (bus.o_drain_valid && first_v < 0) first_v = cyc;
            if (abort_beat >= 0 && exp_idx == abort_beat) begin
                aborted = 1'b1;
                break;
            end
            if (stall && cyc >= 300 && cyc < 350) bus.i_drain_ready = 1'b0;
            else bus.i_drain_ready = (int'($urandom_range(99)) < pct);
            hs = bus.o_drain_valid && bus.i_drain_ready;
            if (hs) begin
                chk("drain_addr", W'(bus.o_drain_addr), W'(exp_idx));
                chk("drain_data", bus.o_drain_data, model[addr_t'(exp_idx)]);
                chk("drain_last", W'(bus.o_drain_last), W'(exp_idx == DEPTH - 1));
                if (exp_idx == DEPTH - 1) last_hs = cyc;
                exp_idx++;
            end
            prev_stall = bus.o_drain_valid && !bus.i_drain_ready;
            prev_data  = bus.o_drain_data;
            prev_addr  = bus.o_drain_addr;
            tick();
            cyc++;
        end
        chk("drain_stall_stable", W'(stall_err), W'(0));
        chk("drain_fifo_bound", W'(max_occ <= FIFO_DEPTH), W'(1));
        if (abort_beat >= 0) begin
            chk("abort_reached", W'(aborted), W'(1));
            rst = 1'b1;
            #1;
            chk("abort_busy", W'(bus.o_busy), W'(0));
            chk("abort_valid", W'(bus.o_drain_valid), W'(0));
            chk("abort_data", bus.o_drain_data, W'(0));
            chk("abort_addr", W'(bus.o_drain_addr), W'(0));
            chk("abort_last", W'(bus.o_drain_last), W'(0));
            chk("abort_psum", bus.o_nxt_psum, W'(0));
            chk("abort_done", W'(bus.o_done), W'(0));
            tick(); tick();
            rst = 1'b0;
            repeat (5) begin
                tick();
                if (bus.o_done || bus.o_busy || bus.o_drain_valid) quiet++;
            end
            chk("abort_no_done", W'(quiet), W'(0));
        end else begin
            chk("drain_beats", W'(exp_idx), W'(DEPTH));
            chk("drain_done_pulses", W'(done_n), W'(1));
            if (pct >= 100) begin
                chk("drain_first_valid", W'(first_v), W'(COMMON_BRAM_DELAY + 1));
                chk("drain_rate", W'(last_hs - first_v), W'(DEPTH - 1));
            end
            tick();
            chk("drain_done_single", W'(bus.o_done), W'(0));
            chk("drain_idle_after", W'(bus.o_busy), W'(0));
        end
        bus.i_drain_ready = 1'b0;
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        rst = 1'b1;
        bus.i_nxt_we = 1'b0;       bus.i_nxt_wraddr = '0;
        bus.i_nxt_din = '0;        bus.i_nxt_rdaddr = '0;
        bus.i_clear_start = 1'b0;  bus.i_drain_start = 1'b0;
        bus.i_drain_ready = 1'b0;
        repeat (3) tick();
        chk("rst_busy", W'(bus.o_busy), W'(0));
        chk("rst_done", W'(bus.o_done), W'(0));
        chk("rst_valid", W'(bus.o_drain_valid), W'(0));
        chk("rst_psum", bus.o_nxt_psum, W'(0));
        chk("rst_data", bus.o_drain_data, W'(0));
        chk("rst_addr_last", W'({bus.o_drain_addr, bus.o_drain_last}), W'(0));
        rst = 1'b0;
        tick();

        // nxt port: latency, read-first collision, pipelined random reads
        wr(addr_t'(6), W'(32'haaaa));
        rd(addr_t'(6), "nxt_rd6");
        wr(addr_t'(5), W'(32'h12345));
        bus.i_nxt_rdaddr = addr_t'(5);
        repeat (COMMON_BRAM_DELAY - 1) tick();
        chk("nxt_lat_early", bus.o_nxt_psum, W'(32'haaaa));
        tick();
        chk("nxt_lat_exact", bus.o_nxt_psum, W'(32'h12345));
        bus.i_nxt_we = 1'b1; bus.i_nxt_wraddr = addr_t'(5); bus.i_nxt_din = W'(7);
        bus.i_nxt_rdaddr = addr_t'(5);
        tick();
        bus.i_nxt_we = 1'b0;
        repeat (COMMON_BRAM_DELAY - 1) tick();
        chk("nxt_read_first", bus.o_nxt_psum, W'(32'h12345));
        model[5] = W'(7);
        rd(addr_t'(5), "nxt_after_write");
        begin
            addr_t ra [8];
            for (int i = 0; i < 8; i++) begin
                ra[i] = addr_t'($urandom_range(DEPTH - 1, 16));
                wr(ra[i], rnd_word());
            end
            for (int j = 0; j < 8 + COMMON_BRAM_DELAY; j++) begin
                if (j < 8) bus.i_nxt_rdaddr = ra[j];
                tick();
                if (j - COMMON_BRAM_DELAY + 1 >= 0 && j - COMMON_BRAM_DELAY + 1 < 8)
                    chk("nxt_pipelined", bus.o_nxt_psum, model[ra[j - COMMON_BRAM_DELAY + 1]]);
            end
        end

        // clear over random contents, with ignored writes
        fill(1'b0);
        clear_run(1'b0, 1'b0);
        rd(addr_t'(0), "clear_rd0");
        rd(addr_t'(2047), "clear_rd2047");
        rd(ADDR_LAST, "clear_rd_last");

        // drain with ready held high
        fill(1'b1);
        drain_run(100, 1'b0, -1);

        // drain with random backpressure and a long stall
        for (int i = 0; i < 200; i++) wr(addr_t'($urandom_range(DEPTH - 1)), rnd_word());
        drain_run(30, 1'b1, -1);

        // start collisions
        clear_run(1'b1, 1'b1);
        rd(addr_t'(DEPTH / 3), "collide_rd");

        // reset mid-drain, then a fresh drain from address 0
        for (int i = 0; i < 300; i++) wr(addr_t'($urandom_range(DEPTH - 1)), rnd_word());
        for (int i = 0; i < 120; i++) wr(addr_t'(i), rnd_word());
        drain_run(100, 1'b0, 100);
        drain_run(100, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
